// File: rtl/req_frontend_pkg.sv
// req_frontend_pkg: shared constants and helpers for the request queue front-end.
//   NREQ_DEF / DW_DEF / DEPTH_DEF : default requester count, payload width, FIFO depth
//   ID_W_DEF                      : width of a requester index ($clog2 of NREQ)
//   onehot_check()                : flags a grant vector with more than one bit set
package req_frontend_pkg;

    localparam int unsigned NREQ_DEF  = 4;
    localparam int unsigned DW_DEF    = 8;
    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned ID_W_DEF  = $clog2(NREQ_DEF);

    // Grant vectors are zero-extended to 32 bits by the caller.
    // Returns 1 when more than one bit is set.
    function automatic logic onehot_check(input logic [31:0] vec);
        return (vec & (vec - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/req_chan_fifo.sv
// req_chan_fifo: single-requester payload FIFO.
//   clk, rstn  : clock, asynchronous active-low reset
//   push       : write push_data (ignored when full)
//   push_data  : payload to enqueue
//   pop        : drop the head entry (ignored when empty)
//   head_data  : current head entry
//   empty/full : occupancy flags, decoded from the registered count
module req_chan_fifo
    import req_frontend_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic          empty,
    output logic          full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_en;
    logic          pop_en;

    assign empty     = (count == CW'(0));
    assign full      = (count == CW'(DEPTH));
    assign head_data = mem[rd_ptr];

    // A full FIFO never accepts, even when popping in the same cycle.
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    // Pointers wrap naturally at DEPTH; count tracks 0..DEPTH.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop_en)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_en, pop_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy is governed by count.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/req_queue_frontend.sv
// req_queue_frontend: per-requester buffering ahead of a fixed-priority arbiter.
//   clk, rstn  : clock, asynchronous active-low reset
//   in_valid   : per-channel push request
//   in_data    : per-channel payload, channel i at [i*DW +: DW]
//   in_ready   : per-channel can-accept (not full)
//   REQ        : request vector to the arbiter (channel non-empty)
//   GNT        : grant vector from the arbiter
//   out_valid / out_data / out_id / out_ready : registered output handshake
//   gnt_err    : one-cycle pulse when GNT has more than one bit set
module req_queue_frontend
    import req_frontend_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          in_valid,
    input  logic [NREQ*DW-1:0]       in_data,
    output logic [NREQ-1:0]          in_ready,
    output logic [NREQ-1:0]          REQ,
    input  logic [NREQ-1:0]          GNT,
    output logic                     out_valid,
    output logic [DW-1:0]            out_data,
    output logic [$clog2(NREQ)-1:0]  out_id,
    input  logic                     out_ready,
    output logic                     gnt_err
);

    localparam int unsigned ID_W = $clog2(NREQ);

    logic [NREQ-1:0] chan_empty;
    logic [NREQ-1:0] chan_full;
    logic [NREQ-1:0] chan_pop;
    logic [DW-1:0]   chan_head [NREQ];

    logic            out_free;
    logic            sel_valid;
    logic [ID_W-1:0] sel_id;
    logic [DW-1:0]   sel_data;
    logic            do_pop;

    // One FIFO per requester.
    for (genvar i = 0; i < NREQ; i++) begin : g_chan
        req_chan_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rstn      (rstn),
            .push      (in_valid[i]),
            .push_data (in_data[i*DW +: DW]),
            .pop       (chan_pop[i]),
            .head_data (chan_head[i]),
            .empty     (chan_empty[i]),
            .full      (chan_full[i])
        );

        assign chan_pop[i] = do_pop && (sel_id == ID_W'(i));
    end

    // Requests and readiness come from registered occupancy only.
    assign REQ      = ~chan_empty;
    assign in_ready = ~chan_full;

    assign out_free = !out_valid || out_ready;

    // Highest granted non-empty channel wins; grants on empty channels are stale.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = '0;
        sel_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (GNT[i] && !chan_empty[i]) begin
                sel_valid = 1'b1;
                sel_id    = ID_W'(i);
                sel_data  = chan_head[i];
            end
        end
    end

    // A grant while the output is blocked is dropped, not deferred.
    assign do_pop = sel_valid && out_free;

    // Output register; data and id hold while out_valid && !out_ready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else if (do_pop) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_id    <= sel_id;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Multi-bit grant flag, registered as a pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gnt_err <= 1'b0;
        end else begin
            gnt_err <= onehot_check(32'(GNT));
        end
    end

endmodule

// File: tb/tb_req_queue_frontend.sv
module tb_req_queue_frontend;

    logic        clk;
    logic        rstn;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        out_ready;
    logic        gnt_err;

    logic        arb_en;
    logic [3:0]  gnt_force;
    logic [3:0]  arb_gnt;

    int n_checks = 0;
    int n_fail   = 0;

    req_queue_frontend #(.NREQ(4), .DW(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .REQ       (req),
        .GNT       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .gnt_err   (gnt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered fixed-priority arbiter model: highest index wins.
    function automatic logic [3:0] hi_onehot(input logic [3:0] v);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 0; i < 4; i++) if (v[i]) r = 4'(1 << i);
        return r;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) arb_gnt <= 4'b0000;
        else       arb_gnt <= hi_onehot(req);
    end

    assign gnt = arb_en ? arb_gnt : gnt_force;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 4'b0000;
        in_data   = 32'h0;
        gnt_force = 4'b0000;
        arb_en    = 1'b0;
        out_ready = 1'b1;
        rstn      = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        step();
    endtask

    typedef struct {
        logic [3:0]  iv;
        logic [31:0] idat;
        logic [3:0]  gf;
        logic        ordy;
        logic        e_ov;
        logic [7:0]  e_od;
        logic [1:0]  e_id;
        logic [3:0]  e_req;
        logic [3:0]  e_ird;
        logic        e_err;
    } vec_t;

    vec_t tbl [11];

    logic [7:0] got_d  [$];
    logic [1:0] got_id [$];

    task automatic collect(input int cycles);
        got_d.delete();
        got_id.delete();
        for (int c = 0; c < cycles; c++) begin
            step();
            if (out_valid) begin
                got_d.push_back(out_data);
                got_id.push_back(out_id);
            end
        end
    endtask

    initial begin
        // iv, idat, gnt, ordy | ov, od, id, req, in_ready, err
        tbl[0]  = '{4'b0010, 32'h0000_1100, 4'b0000, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0010, 4'b1111, 1'b0};
        tbl[1]  = '{4'b1010, 32'h3300_2200, 4'b0000, 1'b1, 1'b0, 8'h00, 2'd0, 4'b1010, 4'b1111, 1'b0};
        tbl[2]  = '{4'b0000, 32'h0,         4'b0010, 1'b1, 1'b1, 8'h11, 2'd1, 4'b1010, 4'b1111, 1'b0};
        tbl[3]  = '{4'b0000, 32'h0,         4'b1010, 1'b1, 1'b1, 8'h33, 2'd3, 4'b0010, 4'b1111, 1'b1};
        tbl[4]  = '{4'b0000, 32'h0,         4'b0000, 1'b1, 1'b0, 8'h33, 2'd3, 4'b0010, 4'b1111, 1'b0};
        tbl[5]  = '{4'b0000, 32'h0,         4'b1000, 1'b1, 1'b0, 8'h33, 2'd3, 4'b0010, 4'b1111, 1'b0};
        tbl[6]  = '{4'b0000, 32'h0,         4'b0010, 1'b0, 1'b1, 8'h22, 2'd1, 4'b0000, 4'b1111, 1'b0};
        tbl[7]  = '{4'b0001, 32'h0000_0044, 4'b0000, 1'b0, 1'b1, 8'h22, 2'd1, 4'b0001, 4'b1111, 1'b0};
        tbl[8]  = '{4'b0000, 32'h0,         4'b0001, 1'b0, 1'b1, 8'h22, 2'd1, 4'b0001, 4'b1111, 1'b0};
        tbl[9]  = '{4'b0000, 32'h0,         4'b0001, 1'b1, 1'b1, 8'h44, 2'd0, 4'b0000, 4'b1111, 1'b0};
        tbl[10] = '{4'b0000, 32'h0,         4'b0000, 1'b1, 1'b0, 8'h44, 2'd0, 4'b0000, 4'b1111, 1'b0};

        do_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_id",    32'(out_id),    32'd0);
        check("rst_gnt_err",   32'(gnt_err),   32'd0);
        check("rst_req",       32'(req),       32'd0);
        check("rst_in_ready",  32'(in_ready),  32'hF);

        // Table: forced grants, mixed push/pop/backpressure.
        for (int r = 0; r < 11; r++) begin
            in_valid  = tbl[r].iv;
            in_data   = tbl[r].idat;
            gnt_force = tbl[r].gf;
            out_ready = tbl[r].ordy;
            step();
            check($sformatf("tbl%0d_out_valid", r), 32'(out_valid), 32'(tbl[r].e_ov));
            check($sformatf("tbl%0d_out_data", r),  32'(out_data),  32'(tbl[r].e_od));
            check($sformatf("tbl%0d_out_id", r),    32'(out_id),    32'(tbl[r].e_id));
            check($sformatf("tbl%0d_req", r),       32'(req),       32'(tbl[r].e_req));
            check($sformatf("tbl%0d_in_ready", r),  32'(in_ready),  32'(tbl[r].e_ird));
            check($sformatf("tbl%0d_gnt_err", r),   32'(gnt_err),   32'(tbl[r].e_err));
        end

        // Single word A5 on channel 2 through the looped-back arbiter.
        do_reset();
        arb_en   = 1'b1;
        in_valid = 4'b0100;
        in_data  = 32'h00A5_0000;
        step();
        in_valid = 4'b0000;
        check("a_req_k",        32'(req),       32'h4);
        check("a_out_valid_k",  32'(out_valid), 32'd0);
        step();
        check("a_gnt_k1",       32'(gnt),       32'h4);
        check("a_out_valid_k1", 32'(out_valid), 32'd0);
        step();
        check("a_out_valid_k2", 32'(out_valid), 32'd1);
        check("a_out_data_k2",  32'(out_data),  32'hA5);
        check("a_out_id_k2",    32'(out_id),    32'd2);
        check("a_req_k2",       32'(req),       32'h0);
        step();
        check("a_out_valid_k3", 32'(out_valid), 32'd0);

        // Fill channel 0, overflow attempt, then drain in order.
        do_reset();
        for (int w = 1; w <= 4; w++) begin
            in_valid = 4'b0001;
            in_data  = 32'(w);
            step();
        end
        check("b_in_ready_full", 32'(in_ready), 32'hE);
        check("b_req_full",      32'(req),      32'h1);
        in_data = 32'h05;
        step();
        check("b_in_ready_hold", 32'(in_ready), 32'hE);
        in_valid = 4'b0000;
        arb_en   = 1'b1;
        collect(12);
        check("b_word_count", 32'(got_d.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            check($sformatf("b_word%0d", k), (k < got_d.size()) ? 32'(got_d[k]) : 32'hFFFF, 32'(k + 1));
        check("b_req_drained", 32'(req), 32'h0);

        // All four channels at once: priority order 3,2,1,0.
        do_reset();
        arb_en   = 1'b1;
        in_valid = 4'b1111;
        in_data  = 32'hD3C2_B1A0;
        step();
        in_valid = 4'b0000;
        check("c_req_all", 32'(req), 32'hF);
        collect(20);
        check("c_word_count", 32'(got_d.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            logic [7:0] exp_d;
            logic [31:0] exp_all;
            exp_all = 32'hD3C2_B1A0;
            exp_d   = exp_all[(3 - k) * 8 +: 8];
            check($sformatf("c_id%0d", k),   (k < got_id.size()) ? 32'(got_id[k]) : 32'hFFFF, 32'(3 - k));
            check($sformatf("c_data%0d", k), (k < got_d.size())  ? 32'(got_d[k])  : 32'hFFFF, 32'(exp_d));
        end

        // Backpressure with a live grant for 5 cycles.
        do_reset();
        in_valid = 4'b0010;
        in_data  = 32'h0000_6100;
        step();
        in_data  = 32'h0000_6200;
        step();
        in_valid  = 4'b0000;
        gnt_force = 4'b0010;
        out_ready = 1'b0;
        step();
        check("d_first_valid", 32'(out_valid), 32'd1);
        check("d_first_data",  32'(out_data),  32'h61);
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("d_hold%0d_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("d_hold%0d_data", c),  32'(out_data),  32'h61);
            check($sformatf("d_hold%0d_req", c),   32'(req),       32'h2);
        end
        out_ready = 1'b1;
        step();
        check("d_resume_data", 32'(out_data), 32'h62);
        check("d_resume_id",   32'(out_id),   32'd1);
        check("d_resume_req",  32'(req),      32'h0);
        gnt_force = 4'b0000;
        step();
        check("d_end_valid", 32'(out_valid), 32'd0);

        // Multi-bit grant 0101.
        do_reset();
        in_valid = 4'b0101;
        in_data  = 32'h0072_0070;
        step();
        in_valid  = 4'b0000;
        gnt_force = 4'b0101;
        step();
        check("e_out_data", 32'(out_data), 32'h72);
        check("e_out_id",   32'(out_id),   32'd2);
        check("e_gnt_err",  32'(gnt_err),  32'd1);
        check("e_req",      32'(req),      32'h1);
        gnt_force = 4'b0000;
        step();
        check("e_gnt_err_clear", 32'(gnt_err), 32'd0);
        gnt_force = 4'b0001;
        step();
        check("e_ch0_data", 32'(out_data), 32'h70);
        check("e_ch0_err",  32'(gnt_err),  32'd0);
        gnt_force = 4'b0000;

        // Asynchronous reset mid-stream.
        do_reset();
        in_valid = 4'b1010;
        in_data  = 32'h9300_8100;
        step();
        in_valid = 4'b0010;
        in_data  = 32'h0000_8200;
        step();
        in_data  = 32'h0000_8300;
        step();
        in_valid  = 4'b0000;
        gnt_force = 4'b1000;
        out_ready = 1'b0;
        step();
        gnt_force = 4'b0000;
        check("f_pre_valid", 32'(out_valid), 32'd1);
        check("f_pre_req",   32'(req),       32'h2);
        #2 rstn = 1'b0;
        #1;
        check("f_rst_valid",    32'(out_valid), 32'd0);
        check("f_rst_req",      32'(req),       32'h0);
        check("f_rst_out_data", 32'(out_data),  32'h0);
        @(negedge clk);
        rstn      = 1'b1;
        out_ready = 1'b1;
        step();
        check("f_post_in_ready", 32'(in_ready),  32'hF);
        check("f_post_req",      32'(req),       32'h0);
        check("f_post_valid",    32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
